// File: rtl/xif_issue_arbiter.sv
// xif_issue_arbiter: shares one CV-X-IF issue/result channel among N_REQ
// requesters with round-robin issue and id-owner result routing.
// Ports: clk_i, rst_i (sync, active-high)
//   req_issue_valid_i/ready_o/accept_o, req_issue_id_i, req_issue_payload_i
//     (flattened; slice i belongs to requester i)
//   co_issue_valid_o/ready_i/accept_i, co_issue_id_o, co_issue_payload_o
//   co_result_valid_i/ready_o, co_result_id_i
//   req_result_valid_o (one-hot owner), req_result_ready_i
//   outstanding_o (3 bits per requester), err_o (one-cycle pulse)
module xif_issue_arbiter #(
   parameter int N_REQ           = 2,
   parameter int X_ID_WIDTH      = 4,
   parameter int PAYLOAD_W       = 128,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_REQ-1:0]            req_issue_valid_i,
   output logic [N_REQ-1:0]            req_issue_ready_o,
   output logic [N_REQ-1:0]            req_issue_accept_o,
   input  logic [N_REQ*X_ID_WIDTH-1:0] req_issue_id_i,
   input  logic [N_REQ*PAYLOAD_W-1:0]  req_issue_payload_i,
   output logic                        co_issue_valid_o,
   input  logic                        co_issue_ready_i,
   input  logic                        co_issue_accept_i,
   output logic [X_ID_WIDTH-1:0]       co_issue_id_o,
   output logic [PAYLOAD_W-1:0]        co_issue_payload_o,
   input  logic                        co_result_valid_i,
   output logic                        co_result_ready_o,
   input  logic [X_ID_WIDTH-1:0]       co_result_id_i,
   output logic [N_REQ-1:0]            req_result_valid_o,
   input  logic [N_REQ-1:0]            req_result_ready_i,
   output logic [N_REQ*3-1:0]          outstanding_o,
   output logic                        err_o
);
   localparam int GW    = $clog2(N_REQ);
   localparam int DEPTH = 2**X_ID_WIDTH;
   localparam int CW    = $clog2(MAX_OUTSTANDING+1);
   localparam logic [CW-1:0] CMAX  = CW'(MAX_OUTSTANDING);
   localparam logic [GW-1:0] GLAST = GW'(N_REQ-1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                           state_q, state_d;
   logic [GW-1:0]                    grant_q, grant_d;
   logic [GW-1:0]                    rr_q, rr_d;
   logic [DEPTH-1:0]                 tvld_q, tvld_d;
   logic [DEPTH-1:0][GW-1:0]         town_q, town_d;
   logic [N_REQ-1:0][CW-1:0]         cnt_q, cnt_d;
   logic                             err_q, err_d;

   logic [N_REQ-1:0][X_ID_WIDTH-1:0] id_a;
   logic [N_REQ-1:0][PAYLOAD_W-1:0]  pl_a;
   logic [N_REQ-1:0]                 elig, inc, dec;
   logic                             found;
   logic [GW-1:0]                    pick, cand, own;
   logic [X_ID_WIDTH-1:0]            gid;

   assign id_a  = req_issue_id_i;
   assign pl_a  = req_issue_payload_i;
   assign gid   = id_a[grant_q];
   assign err_o = err_q;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = req_issue_valid_i[i] && (cnt_q[i] < CMAX)
                   && !tvld_q[id_a[i]];
      end
   end

   // First eligible requester scanning upward from rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      cand  = rr_q;
      for (int k = 0; k < N_REQ; k++) begin
         cand = GW'((int'(rr_q) + k) % N_REQ);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      rr_d               = rr_q;
      tvld_d             = tvld_q;
      town_d             = town_q;
      cnt_d              = cnt_q;
      err_d              = 1'b0;
      inc                = '0;
      dec                = '0;
      own                = '0;
      co_issue_valid_o   = 1'b0;
      co_issue_id_o      = '0;
      co_issue_payload_o = '0;
      req_issue_ready_o  = '0;
      req_issue_accept_o = '0;
      req_result_valid_o = '0;
      co_result_ready_o  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A granted requester withdrawing valid is a protocol
            // violation; the issue is not presented so no handshake
            // can slip through to the coprocessor.
            if (!req_issue_valid_i[grant_q]) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               co_issue_valid_o           = 1'b1;
               co_issue_id_o              = gid;
               co_issue_payload_o         = pl_a[grant_q];
               req_issue_ready_o[grant_q] = co_issue_ready_i;
               if (co_issue_ready_i) begin
                  req_issue_accept_o[grant_q] = co_issue_accept_i;
                  if (co_issue_accept_i) begin
                     tvld_d[gid]  = 1'b1;
                     town_d[gid]  = grant_q;
                     inc[grant_q] = 1'b1;
                  end
                  rr_d    = (grant_q == GLAST) ? '0 : grant_q + 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Result routing; applied after the issue write so a retire of
      // the same index wins.
      if (co_result_valid_i) begin
         if (tvld_q[co_result_id_i]) begin
            own                     = town_q[co_result_id_i];
            req_result_valid_o[own] = 1'b1;
            co_result_ready_o       = req_result_ready_i[own];
            if (req_result_ready_i[own]) begin
               tvld_d[co_result_id_i] = 1'b0;
               dec[own]               = 1'b1;
            end
         end else begin
            co_result_ready_o = 1'b1;
            err_d             = 1'b1;
         end
      end

      for (int i = 0; i < N_REQ; i++) begin
         cnt_d[i] = cnt_q[i] + CW'(inc[i]) - CW'(dec[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         tvld_q  <= '0;
         town_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         tvld_q  <= tvld_d;
         town_q  <= town_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_out
      assign outstanding_o[g*3 +: 3] = 3'(cnt_q[g]);

      a_no_over : assert property (@(posedge clk_i) disable iff (rst_i)
         cnt_q[g] <= CMAX);
      a_no_under : assert property (@(posedge clk_i) disable iff (rst_i)
         !(dec[g] && !inc[g] && cnt_q[g] == '0));
   end

endmodule

// File: tb/tb_xif_issue_arbiter.sv
// tb_xif_issue_arbiter: directed scenarios plus a randomized run
// checked against an id-owner reference model.
module tb_xif_issue_arbiter;
   localparam int N = 2, W = 4, P = 128, MAXO = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       vld, iss_rdy, iss_acc, res_vld, res_rdy;
   logic [N-1:0][W-1:0] ids;
   logic [N-1:0][P-1:0] pls;
   logic               co_vld, co_rdy, co_acc, co_rv, co_rrdy, err;
   logic [W-1:0]       co_id, co_rid;
   logic [P-1:0]       co_pl;
   logic [N*3-1:0]     outst;

   int checks = 0;
   int errors = 0;

   // reference model: owner of each id (-1 = free)
   int own [16];
   int m_rr, m_g;
   bit m_busy, m_err;
   bit [N-1:0] hold;

   always #5 clk = ~clk;

   xif_issue_arbiter #(
      .N_REQ(N), .X_ID_WIDTH(W), .PAYLOAD_W(P), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_issue_valid_i(vld), .req_issue_ready_o(iss_rdy),
      .req_issue_accept_o(iss_acc), .req_issue_id_i(ids),
      .req_issue_payload_i(pls),
      .co_issue_valid_o(co_vld), .co_issue_ready_i(co_rdy),
      .co_issue_accept_i(co_acc), .co_issue_id_o(co_id),
      .co_issue_payload_o(co_pl),
      .co_result_valid_i(co_rv), .co_result_ready_o(co_rrdy),
      .co_result_id_i(co_rid),
      .req_result_valid_o(res_vld), .req_result_ready_i(res_rdy),
      .outstanding_o(outst), .err_o(err)
   );

   function automatic int cnt(int r);
      int c = 0;
      for (int k = 0; k < 16; k++) if (own[k] == r) c++;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vld = '0; ids = '0; pls = '0; co_rdy = 0; co_acc = 0;
      co_rv = 0; co_rid = '0; res_rdy = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      tick(); tick();
      checks++;
      if (co_vld !== 1'b0 || iss_rdy !== 2'b00 || outst !== 6'd0
          || err !== 1'b0 || res_vld !== 2'b00) begin
         errors++;
         $display("FAIL reset: vld=%b rdy=%b out=%h err=%b rv=%b, want 0",
                  co_vld, iss_rdy, outst, err, res_vld);
      end
      rst = 0;
   endtask

   task automatic test_single();
      do_reset();
      vld = 2'b01; ids[0] = 4'd3; pls[0] = {4{$urandom}};
      co_rdy = 1; co_acc = 1;
      #1;
      checks++;
      if (co_vld !== 1'b0) begin
         errors++; $display("FAIL single_idle: co_valid=%b want 0", co_vld);
      end
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || co_id !== 4'd3 || co_pl !== pls[0]) begin
         errors++;
         $display("FAIL single_issue: valid=%b id=%0d want 1/3", co_vld, co_id);
      end
      checks++;
      if (iss_acc !== 2'b01 || iss_rdy !== 2'b01) begin
         errors++;
         $display("FAIL single_acc: acc=%b rdy=%b want 01/01", iss_acc, iss_rdy);
      end
      tick();
      vld = '0;
      #1;
      checks++;
      if (outst[2:0] !== 3'd1) begin
         errors++; $display("FAIL single_cnt: got %0d want 1", outst[2:0]);
      end
      co_rv = 1; co_rid = 4'd3; res_rdy = 2'b11;
      #1;
      checks++;
      if (res_vld !== 2'b01 || co_rrdy !== 1'b1) begin
         errors++;
         $display("FAIL single_res: rv=%b rr=%b want 01/1", res_vld, co_rrdy);
      end
      tick();
      co_rv = 0;
      #1;
      checks++;
      if (outst[2:0] !== 3'd0) begin
         errors++; $display("FAIL single_ret: got %0d want 0", outst[2:0]);
      end
   endtask

   task automatic test_fairness();
      int n = 0, hs, g;
      int sent [N];
      sent[0] = 0; sent[1] = 0;
      do_reset();
      vld = 2'b11; ids[0] = 4'd1; ids[1] = 4'd2;
      co_rdy = 1; co_acc = 1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         #1;
         hs = -1;
         if (co_vld) begin
            g = iss_rdy[1] ? 1 : 0;
            checks++;
            if (g != n % 2) begin
               errors++;
               $display("FAIL fair_grant%0d: got %0d want %0d", n, g, n % 2);
            end
            n++;
            hs = g;
         end
         tick();
         if (hs >= 0) begin
            sent[hs]++;
            if (sent[hs] == 1) ids[hs] = (hs == 1) ? 4'd6 : 4'd5;
            else vld[hs] = 1'b0;
         end
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL fair_timeout: got %0d grants want 4", n);
      end
      #1;
      checks++;
      if (outst !== {3'd2, 3'd2}) begin
         errors++; $display("FAIL fair_cnt: got %h want 12", outst);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      vld = 2'b10; ids[1] = 4'd4; pls[1] = {4{$urandom}};
      co_rdy = 0; co_acc = 1;
      tick();
      vld = 2'b11; ids[0] = 4'd9; pls[0] = {4{$urandom}};
      #1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (co_vld !== 1'b1 || co_id !== 4'd4 || co_pl !== pls[1]
             || iss_rdy !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b id=%0d rdy=%b want 1/4/00",
                     k, co_vld, co_id, iss_rdy);
         end
         tick(); #1;
      end
      co_rdy = 1;
      #1;
      checks++;
      if (iss_rdy !== 2'b10) begin
         errors++; $display("FAIL bp_rdy: got %b want 10", iss_rdy);
      end
      tick();
      vld[1] = 1'b0;
      #1;
      checks++;
      if (co_vld !== 1'b0) begin
         errors++; $display("FAIL bp_gap: co_valid=%b want 0", co_vld);
      end
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || co_id !== 4'd9 || iss_rdy !== 2'b01) begin
         errors++;
         $display("FAIL bp_next: valid=%b id=%0d want 1/9", co_vld, co_id);
      end
      tick();
      vld = '0;
   endtask

   task automatic test_limit();
      do_reset();
      co_rdy = 1; co_acc = 1; vld = 2'b01;
      for (int k = 0; k < 4; k++) begin
         ids[0] = W'(k);
         tick(); tick();
      end
      ids[0] = 4'd4;
      #1;
      checks++;
      if (outst[2:0] !== 3'd4) begin
         errors++; $display("FAIL lim_cnt: got %0d want 4", outst[2:0]);
      end
      vld = 2'b11; ids[1] = 4'd8;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || co_id !== 4'd8) begin
         errors++;
         $display("FAIL lim_other: valid=%b id=%0d want 1/8", co_vld, co_id);
      end
      tick();
      vld[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (co_vld !== 1'b0) begin
            errors++; $display("FAIL lim_block%0d: co_valid=%b want 0", k, co_vld);
         end
         tick();
      end
      co_rv = 1; co_rid = 4'd2; res_rdy = 2'b11;
      #1;
      checks++;
      if (res_vld !== 2'b01) begin
         errors++; $display("FAIL lim_res: got %b want 01", res_vld);
      end
      tick();
      co_rv = 0;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || co_id !== 4'd4) begin
         errors++;
         $display("FAIL lim_resume: valid=%b id=%0d want 1/4", co_vld, co_id);
      end
      tick();
      vld = '0;
   endtask

   task automatic test_reject();
      do_reset();
      vld = 2'b01; ids[0] = 4'd7; co_rdy = 1; co_acc = 0;
      tick(); #1;
      checks++;
      if (iss_acc !== 2'b00 || iss_rdy !== 2'b01) begin
         errors++;
         $display("FAIL rej_acc: acc=%b rdy=%b want 00/01", iss_acc, iss_rdy);
      end
      tick();
      vld = '0;
      #1;
      checks++;
      if (outst !== 6'd0) begin
         errors++; $display("FAIL rej_cnt: got %h want 0", outst);
      end
      co_rv = 1; co_rid = 4'd7; res_rdy = 2'b11;
      #1;
      checks++;
      if (co_rrdy !== 1'b1 || res_vld !== 2'b00) begin
         errors++;
         $display("FAIL rej_drop: rr=%b rv=%b want 1/00", co_rrdy, res_vld);
      end
      tick();
      co_rv = 0;
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL rej_err: got %b want 1", err);
      end
      co_acc = 1; vld = 2'b01; ids[0] = 4'd5;
      tick(); tick();
      vld = 2'b10; ids[1] = 4'd5;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (co_vld !== 1'b0) begin
            errors++; $display("FAIL col_stall%0d: co_valid=%b want 0", k, co_vld);
         end
         tick();
      end
      co_rv = 1; co_rid = 4'd5; res_rdy = 2'b11;
      #1;
      checks++;
      if (res_vld !== 2'b01) begin
         errors++; $display("FAIL col_res: got %b want 01", res_vld);
      end
      tick();
      co_rv = 0;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || co_id !== 4'd5 || iss_rdy !== 2'b10) begin
         errors++;
         $display("FAIL col_grant: valid=%b id=%0d rdy=%b want 1/5/10",
                  co_vld, co_id, iss_rdy);
      end
      tick();
      vld = '0;
   endtask

   task automatic test_errors();
      do_reset();
      co_rv = 1; co_rid = 4'd9; res_rdy = 2'b00;
      #1;
      checks++;
      if (co_rrdy !== 1'b1 || res_vld !== 2'b00) begin
         errors++;
         $display("FAIL err_drop: rr=%b rv=%b want 1/00", co_rrdy, res_vld);
      end
      tick();
      co_rv = 0;
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_pulse: got %b want 1", err);
      end
      tick(); #1;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_once: got %b want 0", err);
      end
      vld = 2'b01; ids[0] = 4'd1; co_rdy = 0;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1) begin
         errors++; $display("FAIL drop_busy: co_valid=%b want 1", co_vld);
      end
      vld = '0;
      tick(); #1;
      checks++;
      if (err !== 1'b1 || co_vld !== 1'b0) begin
         errors++;
         $display("FAIL drop_err: err=%b valid=%b want 1/0", err, co_vld);
      end
      co_rdy = 1; co_acc = 1; vld = 2'b01; ids[0] = 4'd3;
      tick(); tick();
      vld = 2'b10; ids[1] = 4'd4; co_rdy = 0;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b1 || outst[2:0] !== 3'd1) begin
         errors++;
         $display("FAIL rst_pre: valid=%b cnt=%0d want 1/1", co_vld, outst[2:0]);
      end
      rst = 1;
      tick(); #1;
      checks++;
      if (co_vld !== 1'b0 || outst !== 6'd0) begin
         errors++;
         $display("FAIL rst_mid: valid=%b out=%h want 0/0", co_vld, outst);
      end
      rst = 0; vld = '0;
      co_rv = 1; co_rid = 4'd3; res_rdy = 2'b11;
      #1;
      checks++;
      if (res_vld !== 2'b00 || co_rrdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_route: rv=%b rr=%b want 00/1", res_vld, co_rrdy);
      end
      tick();
      co_rv = 0;
   endtask

   task automatic test_random();
      int q[$];
      int o, j;
      bit [N-1:0] e_rdy, e_acc, e_rv;
      bit e_rr, n_err, done;
      do_reset();
      for (int k = 0; k < 16; k++) own[k] = -1;
      m_rr = 0; m_g = 0; m_busy = 0; m_err = 0; hold = '0;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < N; r++) begin
            if (!hold[r] && $urandom_range(2) == 0) begin
               hold[r] = 1'b1;
               ids[r]  = W'($urandom_range(7));
               pls[r]  = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         vld    = hold;
         co_rdy = ($urandom_range(3) != 0);
         co_acc = ($urandom_range(3) != 0);
         co_rv  = 1'($urandom_range(1));
         q = {};
         for (int k = 0; k < 16; k++) if (own[k] >= 0) q.push_back(k);
         if (q.size() > 0 && $urandom_range(3) != 0)
            co_rid = W'(q[$urandom_range(q.size() - 1)]);
         else
            co_rid = W'($urandom_range(15));
         res_rdy = 2'($urandom_range(3));
         #1;
         e_rdy = '0; e_acc = '0; e_rv = '0; e_rr = 0;
         if (m_busy) begin
            e_rdy[m_g] = co_rdy;
            e_acc[m_g] = co_rdy & co_acc;
         end
         o = own[co_rid];
         if (co_rv) begin
            if (o >= 0) begin
               e_rv[o] = 1'b1;
               e_rr    = res_rdy[o];
            end else begin
               e_rr = 1'b1;
            end
         end
         checks++;
         if (co_vld !== m_busy) begin
            errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, co_vld, m_busy);
         end
         if (m_busy) begin
            checks++;
            if (co_id !== ids[m_g] || co_pl !== pls[m_g]) begin
               errors++;
               $display("FAIL rnd_mux c%0d: id=%0d want %0d", c, co_id, ids[m_g]);
            end
         end
         checks++;
         if (iss_rdy !== e_rdy || iss_acc !== e_acc) begin
            errors++;
            $display("FAIL rnd_hs c%0d: rdy=%b acc=%b want %b/%b",
                     c, iss_rdy, iss_acc, e_rdy, e_acc);
         end
         checks++;
         if (res_vld !== e_rv || co_rrdy !== e_rr) begin
            errors++;
            $display("FAIL rnd_res c%0d: rv=%b rr=%b want %b/%b",
                     c, res_vld, co_rrdy, e_rv, e_rr);
         end
         checks++;
         if (outst !== {3'(cnt(1)), 3'(cnt(0))} || err !== m_err) begin
            errors++;
            $display("FAIL rnd_cnt c%0d: out=%h err=%b want %0d,%0d/%b",
                     c, outst, err, cnt(1), cnt(0), m_err);
         end
         n_err = co_rv && (o < 0);
         if (m_busy) begin
            if (co_rdy) begin
               if (co_acc) own[ids[m_g]] = m_g;
               hold[m_g] = 1'b0;
               m_rr   = (m_g + 1) % N;
               m_busy = 0;
            end
         end else begin
            done = 0;
            for (int k = 0; k < N; k++) begin
               j = (m_rr + k) % N;
               if (!done && hold[j] && cnt(j) < MAXO && own[ids[j]] < 0) begin
                  m_g = j; m_busy = 1; done = 1;
               end
            end
         end
         if (co_rv && o >= 0 && res_rdy[o]) own[co_rid] = -1;
         m_err = n_err;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_limit();
      test_reject();
      test_errors();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
